// File: rtl/ti_pipe_in_bank_pkg.sv
// Shared constants and helpers for the host pipe-in buffer bank.
package ti_pipe_in_bank_pkg;

    localparam int EP_WIDTH = 16;
    localparam logic [15:0] AVAIL_SAT = 16'hFFFF;

    // Channel-index width; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [15:0] sat_avail(input logic [31:0] free_words);
        return (free_words > 32'h0000_FFFF) ? AVAIL_SAT : free_words[15:0];
    endfunction

endpackage

// File: rtl/ti_pipe_in_bank_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count and flush.
module ti_fifo_sync #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count == (ADDR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A pop on the same edge frees the slot, so a write to a full FIFO still lands.
    assign rd_ok = rd_en && !empty && !clear;
    assign wr_ok = wr_en && !clear && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ti_pipe_in_bank.sv
// Bank of per-channel pipe-in FIFOs merged round-robin into one registered stream.
module ti_pipe_in_bank
    import ti_pipe_in_bank_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 16,
    localparam int CH_W          = ch_w(NUM_CH)
) (
    input  logic                         ti_clk,
    input  logic                         ti_rst_soft,
    input  logic [NUM_CH-1:0]            ti_in_data_en,
    input  logic [DATA_WIDTH*NUM_CH-1:0] ti_in_data,
    input  logic [NUM_CH-1:0]            ti_in_clear,
    output logic [EP_WIDTH*NUM_CH-1:0]   ti_in_available,
    output logic [NUM_CH-1:0]            ti_in_overflow,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_chan
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]   rd_data [NUM_CH];
    logic [MEM_ADDR_WIDTH:0] count   [NUM_CH];
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       pop;
    logic [NUM_CH-1:0]       eligible;
    logic [CH_W-1:0]         last;
    logic [CH_W-1:0]         grant;
    logic                    grant_valid;
    logic                    load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ti_fifo_sync #(
            .ADDR_W (MEM_ADDR_WIDTH),
            .DATA_W (DATA_WIDTH)
        ) u_fifo (
            .clk     (ti_clk),
            .rst     (ti_rst_soft),
            .clear   (ti_in_clear[c]),
            .wr_en   (ti_in_data_en[c]),
            .wr_data (ti_in_data[DATA_WIDTH*c +: DATA_WIDTH]),
            .rd_en   (pop[c]),
            .rd_data (rd_data[c]),
            .count   (count[c]),
            .full    (full[c]),
            .empty   (empty[c])
        );
    end

    // A channel being flushed is skipped so its discarded data never reaches the output.
    always_comb begin : arb
        int idx;
        idx         = 0;
        load        = !m_valid || m_ready;
        eligible    = ~empty & ~ti_in_clear;
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(last) + 1 + i) % NUM_CH;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant       = CH_W'(idx);
            end
        end
        pop = '0;
        if (load && grant_valid) pop[grant] = 1'b1;
    end

    always_ff @(posedge ti_clk) begin
        if (ti_rst_soft) begin
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_chan         <= '0;
            last           <= CH_W'(NUM_CH - 1);
            ti_in_overflow <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ti_in_available[EP_WIDTH*c +: EP_WIDTH] <= sat_avail(32'(DEPTH));
            end
        end else begin
            if (load) begin
                m_valid <= grant_valid;
                if (grant_valid) begin
                    m_data <= rd_data[grant];
                    m_chan <= grant;
                    last   <= grant;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                ti_in_available[EP_WIDTH*c +: EP_WIDTH] <=
                    sat_avail(32'(DEPTH) - 32'(count[c]));
                if (ti_in_clear[c])
                    ti_in_overflow[c] <= 1'b0;
                else if (ti_in_data_en[c] && full[c] && !pop[c])
                    ti_in_overflow[c] <= 1'b1;
            end
        end
    end

endmodule
